// File: rtl/mvm_seq.sv
// mvm_seq: loads W, b, x over a byte stream, streams row-major products into one MAC, returns M results.
// Define MVM_SAT_EN to clamp overflowed results to the signed 16-bit range on capture.
module mvm_seq #(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic [7:0]  mac_x,
    output logic        mac_valid,
    input  logic [15:0] mac_f,
    input  logic        mac_valid_out,
    input  logic        mac_overflow,
    output logic [15:0] m_data,
    output logic        m_ovf,
    output logic        m_valid,
    input  logic        m_ready
);
    localparam int TOT = M * N + M + N;
    localparam int LW = $clog2(TOT);
    localparam int WW = $clog2(M * N > 1 ? M * N : 2);
    localparam int MW = $clog2(M > 1 ? M : 2);
    localparam int NW = $clog2(N > 1 ? N : 2);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_WAIT, S_OUTPUT} state_t;
    state_t state, state_n;

    logic [7:0]    w_mem [M*N];
    logic [7:0]    b_mem [M];
    logic [7:0]    x_mem [N];
    logic [16:0]   res   [M];
    logic [LW-1:0] lc;
    logic [WW-1:0] wi, n_wi;
    logic [NW-1:0] ik, n_ik;
    logic [MW-1:0] ir, n_ir, wr, rd;
    logic [15:0]   cap_f;
    logic          load_fire, load_last, issue_last, issue_go;
    logic          cap, cap_last, out_fire, out_last;

    assign s_ready    = state == S_LOAD;
    assign load_fire  = s_valid && s_ready;
    assign load_last  = load_fire && lc == LW'(TOT - 1);
    assign issue_last = state == S_COMPUTE && wi == WW'(M * N - 1);
    assign issue_go   = load_last || (state == S_COMPUTE && !issue_last);
    assign cap        = mac_valid_out && (state == S_COMPUTE || state == S_WAIT);
    assign cap_last   = cap && wr == MW'(M - 1);
    assign out_fire   = m_valid && m_ready;
    assign out_last   = out_fire && rd == MW'(M - 1);

    // (wi, ik, ir) name the element currently on the MAC; n_* is the one driven next cycle
    assign n_wi = load_last ? '0 : wi + 1'b1;
    assign n_ik = (load_last || ik == NW'(N - 1)) ? '0 : ik + 1'b1;
    assign n_ir = load_last ? '0 : (ik == NW'(N - 1) ? ir + 1'b1 : ir);

`ifdef MVM_SAT_EN
    // a wrapped sum with bit 15 set means the true sum overflowed positive
    assign cap_f = mac_overflow ? (mac_f[15] ? 16'h7FFF : 16'h8000) : mac_f;
`else
    assign cap_f = mac_f;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_LOAD:    state_n = load_last  ? S_COMPUTE : S_LOAD;
            S_COMPUTE: state_n = issue_last ? S_WAIT    : S_COMPUTE;
            S_WAIT:    state_n = cap_last   ? S_OUTPUT  : S_WAIT;
            S_OUTPUT:  state_n = out_last   ? S_LOAD    : S_OUTPUT;
            default:   state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < M * N; i++)
            if (load_fire && lc == LW'(i)) w_mem[i] <= s_data;
        for (int i = 0; i < M; i++)
            if (load_fire && lc == LW'(M * N + i)) b_mem[i] <= s_data;
        for (int i = 0; i < N; i++)
            if (load_fire && lc == LW'(M * N + M + i)) x_mem[i] <= s_data;
        if (cap) res[wr] <= {mac_overflow, cap_f};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LOAD;
            lc        <= '0;
            wi        <= '0;
            ik        <= '0;
            ir        <= '0;
            wr        <= '0;
            rd        <= '0;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_x     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ovf     <= 1'b0;
        end else begin
            state     <= state_n;
            if (load_fire) lc <= load_last ? '0 : lc + 1'b1;
            wi        <= issue_go ? n_wi : '0;
            ik        <= issue_go ? n_ik : '0;
            ir        <= issue_go ? n_ir : '0;
            mac_valid <= issue_go;
            mac_a     <= issue_go ? w_mem[n_wi] : '0;
            // with N == 1 the only x byte arrives on the same edge it is first issued
            mac_b     <= issue_go ? ((load_last && N == 1) ? s_data : x_mem[n_ik]) : '0;
            mac_x     <= issue_go ? b_mem[n_ir] : '0;
            if (cap) wr <= cap_last ? '0 : wr + 1'b1;
            if (cap_last) begin
                m_valid         <= 1'b1;
                {m_ovf, m_data} <= (M == 1) ? {mac_overflow, cap_f} : res[0];
            end else if (out_fire) begin
                m_valid         <= !out_last;
                {m_ovf, m_data} <= out_last ? 17'd0 : res[rd + 1'b1];
                rd              <= out_last ? '0 : rd + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mvm_seq.sv
// tb_mvm_seq: drives mvm_seq against a behavioural MAC and checks results against y = W*x + b.
module tb_mvm_seq;
    localparam int M = 3;
    localparam int N = 3;
`ifdef MVM_SAT_EN
    localparam logic [15:0] SIGNED_Y0 = 16'h8000;
    localparam logic [15:0] POS_Y0    = 16'h7FFF;
`else
    localparam logic [15:0] SIGNED_Y0 = 16'h4180;
    localparam logic [15:0] POS_Y0    = 16'hBD03;
`endif

    logic        clk = 0;
    logic        reset = 1;
    logic [7:0]  s_data = 0;
    logic        s_valid = 0;
    logic        s_ready;
    logic [7:0]  mac_a, mac_b, mac_x;
    logic        mac_valid;
    logic [15:0] mac_f = 0;
    logic        mac_valid_out = 0;
    logic        mac_overflow = 0;
    logic [15:0] m_data;
    logic        m_ovf, m_valid;
    logic        m_ready = 0;

    int checks = 0;
    int failures = 0;
    int tw[M*N];
    int tbias[M];
    int tx[N];
    logic [15:0] exp_d[M];
    logic        exp_o[M];
    logic [15:0] got_d[M];
    logic        got_o[M];

    always #5 clk = ~clk;

    mvm_seq #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_x(mac_x), .mac_valid(mac_valid),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out), .mac_overflow(mac_overflow),
        .m_data(m_data), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready)
    );

    // MAC stand-in: bias enters with the first product of a row, result two edges after its last product
    int acc = 0;
    int kk = 0;
    logic v1 = 0;
    logic [15:0] f1 = 0;
    logic o1 = 0;
    always @(posedge clk) begin
        if (reset) begin
            kk = 0;
            acc = 0;
            v1 <= 0;
            mac_valid_out <= 0;
            mac_f <= 0;
            mac_overflow <= 0;
        end else begin
            mac_valid_out <= v1;
            mac_f <= f1;
            mac_overflow <= o1;
            v1 <= 0;
            if (mac_valid) begin
                acc = (kk == 0 ? int'(mac_x) : acc) + int'($signed(mac_a)) * int'($signed(mac_b));
                kk++;
                if (kk == N) begin
                    kk = 0;
                    v1 <= 1;
                    f1 <= acc[15:0];
                    o1 <= (acc > 32767 || acc < -32768);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model();
        for (int r = 0; r < M; r++) begin
            int y;
            y = tbias[r];
            for (int k = 0; k < N; k++) y += tw[r*N+k] * tx[k];
            exp_o[r] = (y > 32767 || y < -32768);
`ifdef MVM_SAT_EN
            exp_d[r] = !exp_o[r] ? 16'(y) : (y > 0 ? 16'h7FFF : 16'h8000);
`else
            exp_d[r] = 16'(y);
`endif
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < M*N; i++) tw[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < M; i++) tbias[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < N; i++) tx[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    // returns at the negedge following the final input transfer
    task automatic load_all(input bit gaps);
        logic [7:0] q[$];
        int nrdy, busy;
        nrdy = 0;
        busy = 0;
        for (int i = 0; i < M*N; i++) q.push_back(8'(tw[i]));
        for (int i = 0; i < M; i++) q.push_back(8'(tbias[i]));
        for (int i = 0; i < N; i++) q.push_back(8'(tx[i]));
        foreach (q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                s_valid = 0;
                s_data = 8'($urandom);
                if (m_valid || mac_valid) busy++;
            end
            @(negedge clk);
            if (!s_ready) nrdy++;
            if (m_valid || mac_valid) busy++;
            s_valid = 1;
            s_data = q[i];
        end
        @(negedge clk);
        s_valid = 0;
        s_data = 8'($urandom);
        check("s_ready_in_load", nrdy, 0);
        check("idle_in_load", busy, 0);
    endtask

    task automatic run_batch(input bit gaps, input bit bp);
        int cyc, first, last, nmv, sbad, got, oc;
        bit stalled, rdy;
        logic [16:0] held;
        model();
        load_all(gaps);
        check("mac_valid_rise", mac_valid, 1);
        cyc = 0; first = -1; last = -1; nmv = 0; sbad = 0; got = 0; oc = 0;
        stalled = 0; held = 0;
        while (got < M && cyc < 400) begin
            if (mac_valid) begin
                nmv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (s_ready) sbad++;
            m_ready = 0;
            if (m_valid) begin
                if (stalled) check("hold", {m_ovf, m_data}, held);
                rdy = bp ? (oc >= 5 && $urandom_range(0, 1) == 1) : 1'b1;
                oc++;
                m_ready = rdy;
                if (rdy) begin
                    check("data", m_data, exp_d[got]);
                    check("ovf", m_ovf, exp_o[got]);
                    got_d[got] = m_data;
                    got_o[got] = m_ovf;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = {m_ovf, m_data};
                end
            end
            cyc++;
            @(negedge clk);
        end
        m_ready = 0;
        check("result_count", got, M);
        check("s_ready_after_out", s_ready, 1);
        check("m_valid_after_out", m_valid, 0);
        check("mac_valid_cycles", nmv, M*N);
        check("mac_valid_contig", last - first + 1, M*N);
        check("s_ready_busy", sbad, 0);
    endtask

    initial begin
        int stale;
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_ovf", m_ovf, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_mac_x", mac_x, 0);
        reset = 0;

        for (int i = 0; i < M*N; i++) tw[i] = 1;
        tbias[0] = 0; tbias[1] = 10; tbias[2] = 20;
        tx[0] = 1; tx[1] = 2; tx[2] = 3;
        run_batch(0, 0);
        check("basic_y0", got_d[0], 6);
        check("basic_y1", got_d[1], 16);
        check("basic_y2", got_d[2], 26);
        check("basic_ovf", {got_o[0], got_o[1], got_o[2]}, 0);

        for (int i = 0; i < M*N; i++) tw[i] = (i < N) ? -128 : 0;
        for (int i = 0; i < M; i++) tbias[i] = 0;
        for (int i = 0; i < N; i++) tx[i] = 127;
        run_batch(0, 0);
        check("signed_y0", got_d[0], SIGNED_Y0);
        check("signed_ovf", got_o[0], 1);

        for (int i = 0; i < M*N; i++) tw[i] = 127;
        run_batch(0, 1);
        check("pos_y0", got_d[0], POS_Y0);
        check("pos_ovf", got_o[0], 1);

        repeat (4) begin
            randomize_ops();
            run_batch(0, 0);
            run_batch(1, 1);
        end

        randomize_ops();
        model();
        load_all(0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_mac_valid", mac_valid, 0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid || mac_valid || mac_valid_out) stale++;
        end
        check("midrst_stale", stale, 0);
        randomize_ops();
        run_batch(1, 0);
        randomize_ops();
        run_batch(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
